// File: rtl/interp_phase_serializer.sv
// interp_phase_serializer
//   Control/collection stage behind the 3-phase, 16-lane interpolation select mux.
//   It steps the mux selects through phases 0, 1 and 2, captures the 16 lane
//   results of each phase into a bank, and streams the 48 samples of a frame
//   one per beat over a valid/ready interface.
//
// Optional build macro:
//   INTERP_PIX_SAT_EN  clamp each captured lane to [0, 2^DATA_WIDTH-1].
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      pulse, begins one 48-sample frame (ignored unless idle)
//   c0, c1     mux selects, {c1,c0}: phase0=00, phase1=10, phase2=11
//   mux_out    16 packed lanes, lane k at [k*(DATA_WIDTH+2) +: DATA_WIDTH+2]
//   out_data   current sample (signed, DATA_WIDTH+2 bits)
//   out_valid  out_data valid (registered)
//   out_ready  downstream accepts the beat
//   out_phase  phase of the current beat
//   out_last   high on the 48th beat of the frame
//   busy       frame in progress
//   done       one-cycle pulse after the last beat is accepted
module interp_phase_serializer #(
  parameter int DATA_WIDTH    = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          c0,
  output logic                          c1,
  input  logic [16*(DATA_WIDTH+2)-1:0]  mux_out,
  output logic signed [DATA_WIDTH+1:0]  out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [1:0]                    out_phase,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done
);

  localparam int SW = DATA_WIDTH + 2;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_CAP,
    S_STREAM,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            phase_q, phase_d;
  logic [3:0]            idx_q, idx_d;
  logic [CW-1:0]         settle_q, settle_d;
  logic signed [SW-1:0]  bank_q [16];
  logic signed [SW-1:0]  bank_d [16];
  logic signed [SW-1:0]  lanes  [16];
  logic                  c0_q, c0_d, c1_q, c1_d;
  logic signed [SW-1:0]  out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic [1:0]            out_phase_q, out_phase_d;
  logic                  out_last_q, out_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

`ifdef INTERP_PIX_SAT_EN
  localparam logic signed [SW-1:0] PIX_MAX = SW'((1 << DATA_WIDTH) - 1);

  function automatic logic signed [SW-1:0] pix_clamp(input logic signed [SW-1:0] v);
    if (v < 0)            return '0;
    else if (v > PIX_MAX) return PIX_MAX;
    else                  return v;
  endfunction
`else
  function automatic logic signed [SW-1:0] pix_clamp(input logic signed [SW-1:0] v);
    return v;
  endfunction
`endif

  always_comb begin
    for (int unsigned k = 0; k < 16; k++) begin
      lanes[k] = pix_clamp(mux_out[k*SW +: SW]);
    end
  end

  // All outputs are computed from the next state so they come straight off flops.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    idx_d       = idx_q;
    settle_d    = settle_q;
    bank_d      = bank_q;
    c0_d        = c0_q;
    c1_d        = c1_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_phase_d = out_phase_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        c0_d        = 1'b0;
        c1_d        = 1'b0;
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        if (start) begin
          state_d  = S_SEL;
          phase_d  = 2'd0;
          settle_d = '0;
          busy_d   = 1'b1;
        end
      end
      S_SEL: begin
        if (settle_q == CW'(SETTLE_CYCLES - 1)) state_d = S_CAP;
        else                                     settle_d = settle_q + CW'(1);
      end
      S_CAP: begin
        for (int unsigned k = 0; k < 16; k++) bank_d[k] = lanes[k];
        state_d     = S_STREAM;
        idx_d       = 4'd0;
        // The bank is not written until this edge, so lane 0 is forwarded directly.
        out_data_d  = lanes[0];
        out_valid_d = 1'b1;
        out_phase_d = phase_q;
        out_last_d  = 1'b0;
      end
      S_STREAM: begin
        if (out_ready) begin
          if (idx_q == 4'd15) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            if (phase_q == 2'd2) begin
              state_d = S_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              c0_d    = 1'b0;
              c1_d    = 1'b0;
            end else begin
              state_d  = S_SEL;
              phase_d  = phase_q + 2'd1;
              settle_d = '0;
              c1_d     = 1'b1;
              c0_d     = (phase_q == 2'd1);
            end
          end else begin
            idx_d      = idx_q + 4'd1;
            out_data_d = bank_q[idx_q + 4'd1];
            out_last_d = (phase_q == 2'd2) && (idx_q == 4'd14);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      idx_q       <= '0;
      settle_q    <= '0;
      for (int unsigned k = 0; k < 16; k++) bank_q[k] <= '0;
      c0_q        <= 1'b0;
      c1_q        <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_phase_q <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      idx_q       <= idx_d;
      settle_q    <= settle_d;
      bank_q      <= bank_d;
      c0_q        <= c0_d;
      c1_q        <= c1_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_phase_q <= out_phase_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign c0        = c0_q;
  assign c1        = c1_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_phase = out_phase_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_interp_phase_serializer.sv
// Testbench for interp_phase_serializer (DATA_WIDTH=8, SETTLE_CYCLES=1).
// Mux model: phase0 lane k = k, phase1 lane k = 100+k, phase2 lane k = -k;
// optionally phase0 lane 3 = 300 for the saturation frame.
module tb_interp_phase_serializer;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic                c0, c1;
  logic [159:0]        mux_out;
  logic signed [9:0]   out_data;
  logic                out_valid;
  logic                out_ready;
  logic [1:0]          out_phase;
  logic                out_last;
  logic                busy;
  logic                done;

  interp_phase_serializer #(.DATA_WIDTH(8), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .c0(c0), .c1(c1),
    .mux_out(mux_out), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_phase(out_phase), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic signed [9:0] d;
    logic [1:0]        ph;
    logic              last;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   beats = 0;
  int   dones = 0;
  int   done_cyc = -1;
  int   t_start = 0;
  bit   sat_lane = 1'b0;
  bit   stalled = 1'b0;
  exp_t held;

  always @(posedge clk) cyc++;

  function automatic logic signed [9:0] raw_lane(input int ph, input int k);
    if (ph == 0) return (sat_lane && k == 3) ? 10'sd300 : 10'(k);
    if (ph == 1) return 10'(100 + k);
    return 10'(-k);
  endfunction

  function automatic logic signed [9:0] exp_lane(input int ph, input int k);
    logic signed [9:0] v;
    v = raw_lane(ph, k);
`ifdef INTERP_PIX_SAT_EN
    if (v < 0)   v = 10'sd0;
    if (v > 255) v = 10'sd255;
`endif
    return v;
  endfunction

  always_comb begin
    mux_out = '0;
    for (int k = 0; k < 16; k++) begin
      case ({c1, c0})
        2'b00:   mux_out[k*10 +: 10] = raw_lane(0, k);
        2'b10:   mux_out[k*10 +: 10] = raw_lane(1, k);
        2'b11:   mux_out[k*10 +: 10] = raw_lane(2, k);
        default: mux_out[k*10 +: 10] = 10'sd511;
      endcase
    end
  end

  task automatic check(input string name, input longint act, input longint expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted beat.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (stalled) begin
          check("stall_data", out_data, held.d);
          check("stall_phase", out_phase, held.ph);
          check("stall_last", out_last, held.last);
        end
        check("sel_code", {c1, c0}, (out_phase == 2'd0) ? 2'b00 : (out_phase == 2'd1) ? 2'b10 : 2'b11);
        if (out_ready) begin
          stalled = 1'b0;
          if (q.size() == 0) begin
            check("extra_beat", 1, 0);
          end else begin
            exp_t e;
            e = q.pop_front();
            check("beat_data", out_data, e.d);
            check("beat_phase", out_phase, e.ph);
            check("beat_last", out_last, e.last);
          end
          beats++;
        end else begin
          stalled = 1'b1;
          held    = '{d: out_data, ph: out_phase, last: out_last};
        end
      end else begin
        stalled = 1'b0;
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  // mode 0: ready always 1; mode 1: ready pattern 1,0,0 repeating.
  task automatic run_frame(input int mode, input int start_at, input int reset_at, input bit chk_timing);
    int n;
    bit injected;
    beats = 0; dones = 0; done_cyc = -1; injected = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    out_ready = 1'b1;
    for (int ph = 0; ph < 3; ph++)
      for (int k = 0; k < 16; k++)
        q.push_back('{d: exp_lane(ph, k), ph: 2'(ph), last: (ph == 2 && k == 15)});
    @(posedge clk);
    @(negedge clk);
    t_start = cyc;
    start = 1'b0;
    n = 0;
    while (dones == 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      out_ready = (mode == 0) ? 1'b1 : (n % 3 == 0);
      if (start_at >= 0 && !injected && beats == start_at) begin
        start = 1'b1;
        injected = 1'b1;
      end
      if (reset_at >= 0 && beats >= reset_at) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        q.delete();
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        repeat (5) @(posedge clk);
        #1;
        check("rst_no_done", dones, 0);
        check("rst_idle_busy", busy, 0);
        return;
      end
    end
    start = 1'b0;
    check("frame_timeout", (n < 400) ? 1 : 0, 1);
    repeat (4) @(posedge clk);
    #1;
    check("frame_beats", beats, 48);
    check("frame_dones", dones, 1);
    check("frame_queue_empty", q.size(), 0);
    check("idle_busy", busy, 0);
    if (chk_timing) check("done_latency", done_cyc - t_start, 54);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    // 1: reset and idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_c0", c0, 0);
    check("rst_c1", c1, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_phase", out_phase, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy0", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("idle_busy0", busy, 0);
    check("idle_sel", {c1, c0}, 0);

    run_frame(0, -1, -1, 1'b1);   // 2: full frame
    run_frame(1, -1, -1, 1'b0);   // 3: backpressure
    run_frame(0, 20, -1, 1'b1);   // 4: start while busy
    run_frame(0, -1, 30, 1'b0);   // 5: reset mid-frame
    run_frame(0, -1, -1, 1'b1);   //    clean frame afterwards
    sat_lane = 1'b1;              // 6: lane value 300 / negative lanes
    run_frame(0, -1, -1, 1'b1);
    sat_lane = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
